// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: FSM state encoding and byte-to-word address helpers.
// The reader side imports this package as well.
package fb_pkg;

  localparam int unsigned FB_WORD_BYTES = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ACCEPT_LO  = 3'd1,
    ACCEPT_HI  = 3'd2,
    WRITE_WAIT = 3'd3,
    FILL_WAIT  = 3'd4
  } fb_state_t;

  // 64-bit word address of a byte address (byte address is a multiple of 8).
  function automatic logic [28:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr[31:3];
  endfunction

endpackage

// File: rtl/frame_buffer_writer.sv
// Frame-buffer write master: packs two 32-bit pixels per 64-bit Avalon-MM write, or fills
// the whole frame with a single colour, walking the frame linearly and pulsing frame_done.
module frame_buffer_writer
  import fb_pkg::*;
#(
  parameter logic [31:0] ADDRESS = 32'h0,
  parameter logic [31:0] LENGTH  = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [28:0] address,
  output logic [7:0]  burstcount,
  input  logic        waitrequest,
  input  logic [63:0] readdata,
  input  logic        readdatavalid,
  output logic        read,
  output logic [63:0] writedata,
  output logic [7:0]  byteenable,
  output logic        write,
  input  logic        frame_start,
  input  logic        fill_request,
  input  logic [31:0] fill_color,
  input  logic [31:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [31:0] debug_value0,
  output logic [31:0] debug_value1
);

  localparam logic [28:0] BASE_WORD = word_addr(ADDRESS);
  localparam logic [28:0] LAST_WORD = BASE_WORD + word_addr(LENGTH) - 29'd1;

  fb_state_t   state, state_n;
  logic [28:0] address_q, address_n;
  logic [63:0] data_q, data_n;
  logic        write_q, write_n;
  logic        done_q, done_n;
  logic        half_q, half_n;
  logic        accepted;
  logic        last_word;

  // Read side of the port is never used by this master.
  logic        unused_read_side;
  assign unused_read_side = ^{readdata, readdatavalid};

  assign accepted  = write_q && !waitrequest;
  assign last_word = (address_q == LAST_WORD);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      address_q <= BASE_WORD;
      data_q    <= '0;
      write_q   <= 1'b0;
      done_q    <= 1'b0;
      half_q    <= 1'b0;
    end else begin
      state     <= state_n;
      address_q <= address_n;
      data_q    <= data_n;
      write_q   <= write_n;
      done_q    <= done_n;
      half_q    <= half_n;
    end
  end

  always_comb begin
    state_n     = state;
    address_n   = address_q;
    data_n      = data_q;
    write_n     = write_q;
    done_n      = 1'b0;
    half_n      = half_q;
    pixel_ready = 1'b0;

    case (state)
      IDLE: begin
        // Fill has priority; a simultaneous frame_start is dropped.
        if (fill_request) begin
          data_n  = {fill_color, fill_color};
          write_n = 1'b1;
          state_n = FILL_WAIT;
        end else if (frame_start) begin
          half_n  = 1'b0;
          state_n = ACCEPT_LO;
        end
      end

      ACCEPT_LO: begin
        pixel_ready = 1'b1;
        if (pixel_valid) begin
          data_n[31:0] = pixel_data;
          half_n       = 1'b1;
          state_n      = ACCEPT_HI;
        end
      end

      ACCEPT_HI: begin
        pixel_ready = 1'b1;
        if (pixel_valid) begin
          data_n[63:32] = pixel_data;
          half_n        = 1'b0;
          write_n       = 1'b1;
          state_n       = WRITE_WAIT;
        end
      end

      WRITE_WAIT: begin
        if (accepted) begin
          write_n = 1'b0;
          if (last_word) begin
            address_n = BASE_WORD;
            done_n    = 1'b1;
            state_n   = IDLE;
          end else begin
            address_n = address_q + 29'd1;
            state_n   = ACCEPT_LO;
          end
        end
      end

      FILL_WAIT: begin
        // write stays asserted across words so an unstalled fill runs one word per cycle.
        if (accepted) begin
          if (last_word) begin
            write_n   = 1'b0;
            address_n = BASE_WORD;
            done_n    = 1'b1;
            state_n   = IDLE;
          end else begin
            address_n = address_q + 29'd1;
          end
        end
      end

      default: begin
        write_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  assign address      = address_q;
  assign writedata    = data_q;
  assign write        = write_q;
  assign frame_done   = done_q;
  assign busy         = (state != IDLE);
  assign burstcount   = 8'h01;
  assign byteenable   = 8'hFF;
  assign read         = 1'b0;
  assign debug_value0 = {24'b0, state, write_q, waitrequest, pixel_valid, pixel_ready, half_q};
  assign debug_value1 = {3'b0, address_q};

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Scoreboard bench for frame_buffer_writer (ADDRESS=0x100, LENGTH=32 -> words 0x20..0x23).
module tb_frame_buffer_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic [28:0] address;
  logic [7:0]  burstcount;
  logic        waitrequest;
  logic [63:0] readdata;
  logic        readdatavalid;
  logic        read;
  logic [63:0] writedata;
  logic [7:0]  byteenable;
  logic        write;
  logic        frame_start;
  logic        fill_request;
  logic [31:0] fill_color;
  logic [31:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        busy;
  logic        frame_done;
  logic [31:0] debug_value0;
  logic [31:0] debug_value1;

  typedef struct packed {
    logic [28:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  pass_cnt = 0;
  int  total_cnt = 0;
  int  done_cnt = 0;

  frame_buffer_writer #(.ADDRESS(32'h100), .LENGTH(32'd32)) dut (
    .clock(clock), .reset(reset), .address(address), .burstcount(burstcount),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
    .read(read), .writedata(writedata), .byteenable(byteenable), .write(write),
    .frame_start(frame_start), .fill_request(fill_request), .fill_color(fill_color),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .busy(busy), .frame_done(frame_done), .debug_value0(debug_value0),
    .debug_value1(debug_value1)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Monitor: every accepted write is compared against the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      if (frame_done) done_cnt++;
      if (write && !waitrequest) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", {35'b0, address}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", {35'b0, address}, {35'b0, e.addr});
          check("wr_data", writedata, e.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic feed(input logic [31:0] p);
    bit taken = 0;
    pixel_data  = p;
    pixel_valid = 1'b1;
    for (int i = 0; i < 50 && !taken; i++) begin
      @(negedge clock);
      if (pixel_ready) begin
        @(posedge clock);
        #1;
        taken = 1;
      end
    end
    pixel_valid = 1'b0;
    if (!taken) check("pixel_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int target);
    int i = 0;
    while (done_cnt < target && i < 100) begin
      tick(1);
      i++;
    end
    if (done_cnt < target) check("frame_done_timeout", done_cnt, target);
  endtask

  task automatic push_pixels(input logic [31:0] first);
    for (int w = 0; w < 4; w++) begin
      wr_t e;
      e.addr = 29'h20 + 29'(w);
      e.data = {first + 32'(2 * w + 1), first + 32'(2 * w)};
      exp_q.push_back(e);
    end
  endtask

  task automatic push_fill(input logic [31:0] c);
    for (int w = 0; w < 4; w++) begin
      wr_t e;
      e.addr = 29'h20 + 29'(w);
      e.data = {c, c};
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    int n;
    reset = 1'b1; waitrequest = 1'b0; readdata = '0; readdatavalid = 1'b0;
    frame_start = 1'b0; fill_request = 1'b0; fill_color = '0;
    pixel_data = '0; pixel_valid = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);

    check("rst_write", {63'b0, write}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_ready", {63'b0, pixel_ready}, 64'd0);
    check("rst_address", {35'b0, address}, 64'h20);
    check("rst_done", {63'b0, frame_done}, 64'd0);
    check("rst_debug0", {32'b0, debug_value0}, 64'd0);
    check("rst_debug1", {32'b0, debug_value1}, 64'h20);

    // Streamed frame, no stall.
    d0 = done_cnt;
    push_pixels(32'h1);
    pulse_start();
    for (int p = 1; p <= 8; p++) feed(32'(p));
    wait_done(d0 + 1);
    tick(3);
    check("frame_done_once", done_cnt, d0 + 1);
    check("frame_addr_wrap", {35'b0, address}, 64'h20);
    check("frame_idle", {63'b0, busy}, 64'd0);

    // Fill, one word per cycle; colour latched at the request.
    d0 = done_cnt;
    push_fill(32'h00FF00FF);
    fill_color = 32'h00FF00FF;
    fill_request = 1'b1;
    tick(1);
    fill_request = 1'b0;
    fill_color = 32'hDEADBEEF;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!write) break;
      check("fill_no_ready", {63'b0, pixel_ready}, 64'd0);
      n++;
      tick(1);
    end
    check("fill_write_cycles", n, 4);
    wait_done(d0 + 1);
    tick(2);
    check("fill_done_once", done_cnt, d0 + 1);
    check("fill_addr_wrap", {35'b0, address}, 64'h20);

    // Stall on word 0x21.
    d0 = done_cnt;
    push_pixels(32'h31);
    pulse_start();
    feed(32'h31);
    feed(32'h32);
    tick(1);
    waitrequest = 1'b1;
    feed(32'h33);
    feed(32'h34);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_write", {63'b0, write}, 64'd1);
      check("stall_addr", {35'b0, address}, 64'h21);
      check("stall_data", writedata, 64'h00000034_00000033);
      check("stall_ready", {63'b0, pixel_ready}, 64'd0);
    end
    @(posedge clock);
    #1;
    waitrequest = 1'b0;
    for (int p = 5; p <= 8; p++) feed(32'h30 + 32'(p));
    wait_done(d0 + 1);
    tick(2);
    check("stall_done_once", done_cnt, d0 + 1);

    // Simultaneous start and fill: fill wins, later starts ignored.
    d0 = done_cnt;
    push_fill(32'h12345678);
    fill_color = 32'h12345678;
    fill_request = 1'b1;
    frame_start = 1'b1;
    tick(1);
    fill_request = 1'b0;
    frame_start = 1'b0;
    tick(1);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    wait_done(d0 + 1);
    tick(3);
    check("both_done_once", done_cnt, d0 + 1);
    check("both_idle_busy", {63'b0, busy}, 64'd0);
    check("both_idle_ready", {63'b0, pixel_ready}, 64'd0);

    // Reset while a word waits in WRITE_WAIT: the word is discarded.
    waitrequest = 1'b1;
    pulse_start();
    feed(32'hA1);
    feed(32'hA2);
    tick(2);
    check("pre_reset_write", {63'b0, write}, 64'd1);
    reset = 1'b1;
    tick(1);
    check("reset_write", {63'b0, write}, 64'd0);
    check("reset_addr", {35'b0, address}, 64'h20);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_data", writedata, 64'd0);
    reset = 1'b0;
    waitrequest = 1'b0;
    tick(1);
    d0 = done_cnt;
    push_pixels(32'h11);
    pulse_start();
    for (int p = 0; p < 8; p++) feed(32'h11 + 32'(p));
    wait_done(d0 + 1);
    tick(2);
    check("post_reset_done", done_cnt, d0 + 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
